// File: rtl/sim_pkg.sv
// Shared state encoding for the simulation run controller and the stats collectors.
package sim_pkg;

    localparam int SIM_STATE_W = 3;

    typedef enum logic [SIM_STATE_W-1:0] {
        INVALID     = 3'd0,
        INITIALIZED = 3'd1,
        WARMUP      = 3'd2,
        RUNNING     = 3'd3,
        PAUSED      = 3'd4,
        DRAINING    = 3'd5,
        COMPLETED   = 3'd6
    } sim_state_e;

endpackage

// File: rtl/sim_sat_counter.sv
// Unsigned saturating up-counter with synchronous clear; clear wins over increment.
module sim_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    assign at_max = &value;

    always_ff @(posedge clk) begin
        if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= sat_inc(value);
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// Simulation lifecycle sequencer: init, warmup, measured run, pause, drain, completion.
// Optional heartbeat output enabled by defining SIM_RUN_CTRL_HEARTBEAT_EN.
module sim_run_controller
    import sim_pkg::*;
#(
    parameter int CYCLE_WIDTH     = 32,
    parameter int HEARTBEAT_SHIFT = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   abort,
    input  logic [CYCLE_WIDTH-1:0] cfg_warmup,
    input  logic [CYCLE_WIDTH-1:0] cfg_max,
    input  logic                   drain_idle,
    output logic [SIM_STATE_W-1:0] state,
    output logic [CYCLE_WIDTH-1:0] current_cycle,
    output logic [CYCLE_WIDTH-1:0] measured_cycle,
    output logic                   done,
    output logic                   aborted,
    output logic                   heartbeat
);

    localparam logic [SIM_STATE_W-1:0] ST_INVALID     = INVALID;
    localparam logic [SIM_STATE_W-1:0] ST_INITIALIZED = INITIALIZED;
    localparam logic [SIM_STATE_W-1:0] ST_WARMUP      = WARMUP;
    localparam logic [SIM_STATE_W-1:0] ST_RUNNING     = RUNNING;
    localparam logic [SIM_STATE_W-1:0] ST_PAUSED      = PAUSED;
    localparam logic [SIM_STATE_W-1:0] ST_DRAINING    = DRAINING;
    localparam logic [SIM_STATE_W-1:0] ST_COMPLETED   = COMPLETED;

    localparam logic [CYCLE_WIDTH:0] ONE_X      = {{CYCLE_WIDTH{1'b0}}, 1'b1};
    localparam logic [CYCLE_WIDTH:0] ALL_ONES_X = {1'b0, {CYCLE_WIDTH{1'b1}}};

    logic [SIM_STATE_W-1:0] state_q, state_d, resume_q;
    logic [CYCLE_WIDTH-1:0] warm_q, max_q;
    logic [CYCLE_WIDTH:0]   cur_nxt, meas_nxt;
    logic in_phase, abort_ok, hold, launch, rearm;
    logic cur_inc, meas_inc, cnt_clr, warm_exit, run_exit;
    logic meas_at_max, unused_cur_at_max;

    assign in_phase = (state_q == ST_WARMUP) || (state_q == ST_RUNNING);
    assign abort_ok = abort && (state_q inside {ST_INITIALIZED, ST_WARMUP, ST_RUNNING,
                                                ST_PAUSED, ST_DRAINING});
    assign launch   = (state_q == ST_INITIALIZED) && start && !abort;
    assign rearm    = (state_q == ST_COMPLETED) && start;

    // A cycle that is diverted to PAUSED or COMPLETED does not count, so a resumed
    // phase re-evaluates its exit against exactly the counts it was interrupted at.
    assign hold     = abort_ok || (in_phase && pause);
    assign cur_inc  = !hold && (in_phase || (state_q == ST_DRAINING));
    assign meas_inc = !hold && (state_q == ST_RUNNING);
    assign cnt_clr  = !reset_n || launch || rearm;

    assign cur_nxt   = {1'b0, current_cycle} + ONE_X;
    assign meas_nxt  = {1'b0, measured_cycle} + ONE_X;
    assign warm_exit = (cur_nxt == {1'b0, warm_q});
    assign run_exit  = (max_q == '0) ? ((meas_nxt == ALL_ONES_X) || meas_at_max)
                                     : (meas_nxt == {1'b0, max_q});

    sim_sat_counter #(.WIDTH(CYCLE_WIDTH)) u_cur_cnt (
        .clk    (clk),
        .clr    (cnt_clr),
        .inc    (cur_inc),
        .value  (current_cycle),
        .at_max (unused_cur_at_max)
    );

    sim_sat_counter #(.WIDTH(CYCLE_WIDTH)) u_meas_cnt (
        .clk    (clk),
        .clr    (cnt_clr),
        .inc    (meas_inc),
        .value  (measured_cycle),
        .at_max (meas_at_max)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INVALID:     state_d = ST_INITIALIZED;
            ST_INITIALIZED: if (start) state_d = (cfg_warmup != '0) ? ST_WARMUP : ST_RUNNING;
            ST_WARMUP: begin
                if (pause)          state_d = ST_PAUSED;
                else if (warm_exit) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (pause)         state_d = ST_PAUSED;
                else if (run_exit) state_d = ST_DRAINING;
            end
            ST_PAUSED:      if (!pause) state_d = resume_q;
            ST_DRAINING:    if (drain_idle) state_d = ST_COMPLETED;
            ST_COMPLETED:   if (start) state_d = ST_INITIALIZED;
            default:        state_d = ST_INVALID;
        endcase
        if (abort_ok) state_d = ST_COMPLETED;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_INVALID;
            resume_q <= ST_INVALID;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == ST_COMPLETED) && (state_q != ST_COMPLETED);
            if (in_phase && pause && !abort_ok) resume_q <= state_q;
            if (abort_ok)             aborted <= 1'b1;
            else if (launch || rearm) aborted <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            warm_q <= cfg_warmup;
            max_q  <= cfg_max;
        end
    end

    assign state = state_q;

`ifdef SIM_RUN_CTRL_HEARTBEAT_EN
    localparam logic [HEARTBEAT_SHIFT-1:0] HB_ONE = {{(HEARTBEAT_SHIFT-1){1'b0}}, 1'b1};
    logic [HEARTBEAT_SHIFT-1:0] hb_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || launch) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else begin
            heartbeat <= cur_inc && (&hb_cnt);
            if (cur_inc) hb_cnt <= hb_cnt + HB_ONE;
        end
    end
`else
    localparam int unused_hb_shift = HEARTBEAT_SHIFT;
    assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_sim_run_controller.sv
// Builds per-cycle expected traces of whole runs from the lifecycle rules, then replays them on the DUT.
module tb_sim_run_controller;
    import sim_pkg::*;

    localparam int CW  = 4;
    localparam int HB  = 2;
    localparam int SAT = (1 << CW) - 1;

    typedef struct {
        bit rn, start, pause, abort, idle, launch, adv;
        int w, m;
        int st, cur, meas;
        bit dn, abd;
    } step_t;

    step_t tr[$];
    int total = 0;
    int bad   = 0;
    int hb_cnt = 0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0, drain_idle = 1'b0;
    logic [CW-1:0] cfg_warmup = '0, cfg_max = '0;
    logic [2:0]    state;
    logic [CW-1:0] current_cycle, measured_cycle;
    logic          done, aborted, heartbeat;

    sim_run_controller #(.CYCLE_WIDTH(CW), .HEARTBEAT_SHIFT(HB)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .abort(abort),
        .cfg_warmup(cfg_warmup), .cfg_max(cfg_max), .drain_idle(drain_idle),
        .state(state), .current_cycle(current_cycle), .measured_cycle(measured_cycle),
        .done(done), .aborted(aborted), .heartbeat(heartbeat)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int x);
        return (x < SAT) ? x + 1 : SAT;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input bit rn, input bit st_in, input bit pz, input bit ab_in, input bit idle,
                       input int st, input int cur, input int meas, input bit dn, input bit abd,
                       input bit launch, input bit adv);
        step_t s;
        s.rn = rn; s.start = st_in; s.pause = pz; s.abort = ab_in; s.idle = idle;
        s.launch = launch; s.adv = adv;
        s.w = $urandom_range(0, SAT); s.m = $urandom_range(0, SAT);
        s.st = st; s.cur = cur; s.meas = meas; s.dn = dn; s.abd = abd;
        tr.push_back(s);
    endtask

    task automatic add_reset();
        add(0, rb(), rb(), rb(), rb(), INVALID, 0, 0, 0, 0, 0, 0);
    endtask

    // One launch from INITIALIZED to the following INITIALIZED. Optional pause before
    // active tick p, drain stall of dwait cycles, and a cut (abort or reset) at entry cut_at.
    task automatic gen_run(input int w, input int m, input int p, input int plen, input int dwait,
                           input int cut_at, input bit cut_reset);
        int cur = 0, meas = 0, nst, ph, idx;
        int lim = (m == 0) ? SAT : m;
        int nt  = w + lim;
        step_t prev;
        add(1, 1, rb(), 0, rb(), (w != 0) ? WARMUP : RUNNING, 0, 0, 0, 0, 1, 0);
        tr[tr.size()-1].w = w;
        tr[tr.size()-1].m = m;
        for (int k = 0; k < nt; k++) begin
            ph = (k < w) ? WARMUP : RUNNING;
            if (k == p) begin
                for (int j = 0; j < plen; j++) add(1, rb(), 1, 0, rb(), PAUSED, cur, meas, 0, 0, 0, 0);
                add(1, rb(), 0, 0, rb(), ph, cur, meas, 0, 0, 0, 0);
            end
            cur = sat(cur);
            if (k >= w) meas = sat(meas);
            if (k == nt - 1)      nst = DRAINING;
            else if (k == w - 1)  nst = RUNNING;
            else                  nst = ph;
            add(1, rb(), 0, 0, rb(), nst, cur, meas, 0, 0, 0, 1);
        end
        for (int d = 0; d < dwait; d++) begin
            cur = sat(cur);
            add(1, rb(), rb(), 0, 0, DRAINING, cur, meas, 0, 0, 0, 1);
        end
        cur = sat(cur);
        add(1, rb(), rb(), 0, 1, COMPLETED, cur, meas, 1, 0, 0, 1);
        add(1, 0, rb(), rb(), rb(), COMPLETED, cur, meas, 0, 0, 0, 0);
        idx = cut_at;
        if (cut_at > 0 && idx < tr.size() && (cut_reset || tr[idx-1].st != COMPLETED)) begin
            prev = tr[idx-1];
            while (tr.size() > idx) void'(tr.pop_back());
            if (cut_reset) begin
                add_reset();
                add(1, 0, rb(), 0, rb(), INITIALIZED, 0, 0, 0, 0, 0, 0);
                return;
            end
            add(1, rb(), rb(), 1, rb(), COMPLETED, prev.cur, prev.meas, 1, 1, 0, 0);
            add(1, 0, rb(), rb(), rb(), COMPLETED, prev.cur, prev.meas, 0, 1, 0, 0);
        end
        add(1, 1, rb(), rb(), rb(), INITIALIZED, 0, 0, 0, 0, 0, 0);
        add(1, 0, rb(), 0, rb(), INITIALIZED, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    task automatic play();
        bit hb_exp;
        foreach (tr[i]) begin
            reset_n    = tr[i].rn;
            start      = tr[i].start;
            pause      = tr[i].pause;
            abort      = tr[i].abort;
            drain_idle = tr[i].idle;
            cfg_warmup = CW'(tr[i].w);
            cfg_max    = CW'(tr[i].m);
            @(posedge clk);
            #1;
            hb_exp = 1'b0;
            if (!tr[i].rn || tr[i].launch) begin
                hb_cnt = 0;
            end else if (tr[i].adv) begin
                hb_exp = (hb_cnt == (1 << HB) - 1);
                hb_cnt = (hb_cnt + 1) % (1 << HB);
            end
`ifndef SIM_RUN_CTRL_HEARTBEAT_EN
            hb_exp = 1'b0;
`endif
            chk("state", i, 32'(state), tr[i].st);
            chk("current_cycle", i, 32'(current_cycle), tr[i].cur);
            chk("measured_cycle", i, 32'(measured_cycle), tr[i].meas);
            chk("done", i, 32'(done), 32'(tr[i].dn));
            chk("aborted", i, 32'(aborted), 32'(tr[i].abd));
            chk("heartbeat", i, 32'(heartbeat), 32'(hb_exp));
        end
        tr.delete();
    endtask

    initial begin
        int w, m, lim, p, plen, dw, cut;
        bit crst;
        add_reset();
        add_reset();
        add(1, 0, 0, 0, 0, INITIALIZED, 0, 0, 0, 0, 0, 0);
        play();

        gen_run(3, 5, -1, 0, 0, -1, 0);   play();
        gen_run(0, 2, -1, 0, 0, -1, 0);   play();
        gen_run(1, 6, 3, 4, 0, -1, 0);    play();
        gen_run(2, 3, -1, 0, 10, -1, 0);  play();
        gen_run(2, 6, 4, 5, 0, 7, 0);     play();

        add(1, 0, 0, 1, 0, COMPLETED, 0, 0, 1, 1, 0, 0);
        add(1, 1, 0, 0, 0, INITIALIZED, 0, 0, 0, 0, 0, 0);
        play();

        gen_run(4, 0, -1, 0, 2, -1, 0);   play();
        gen_run(1, 8, -1, 0, 0, 5, 1);    play();

        for (int r = 0; r < 30; r++) begin
            w    = $urandom_range(0, SAT);
            m    = $urandom_range(0, SAT);
            lim  = (m == 0) ? SAT : m;
            p    = ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, w + lim - 1)) : -1;
            plen = $urandom_range(1, 4);
            dw   = $urandom_range(0, 5);
            cut  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, w + lim + plen + dw + 3)) : -1;
            crst = ($urandom_range(0, 3) == 0);
            gen_run(w, m, p, plen, dw, cut, crst);
            play();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
